int_ctrl_unit: RTL and testbench
================================

// Module: int_ctrl_unit
// PURPOSE
//  Interrupt entry/return sequencer directly upstream of the execution unit.
//  Synchronises external IRQ/FIQ lines and prioritises FIQ over IRQ.
//  At an instruction boundary it drives the EU strobes that save CPSR to SPSR/SPSR_fiq,
//  save the return address to Link/Link_fiq, mask CPSR and load the vector into IP.
//  On reti it restores CPSR from the matching saved PSR and reloads IP from the link.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser flops on irq_in/fiq_in (>=2)
//  I_BIT        10     CPSR bit index of the IRQ mask (I[0] in the flags word)
//  F_BIT        13     CPSR bit index of the FIQ mask (F[0] in the flags word)
//  IRQ_VEC_SEL  3'd3   IP_sel code that selects the IRQ vector
//  FIQ_VEC_SEL  3'd4   IP_sel code that selects the FIQ vector
//  RET_SEL      3'd5   IP_sel code that selects the Link/Link_fiq return address
// PORTS
//  W_Clk         in   1   system clock, all state on the rising edge
//  reset         in   1   synchronous, active-high
//  irq_in        in   1   asynchronous level IRQ request
//  fiq_in        in   1   asynchronous level FIQ request
//  boundary      in   1   control unit is at an instruction boundary and may be preempted
//  reti          in   1   control unit decoded return-from-interrupt (1-cycle pulse)
//  CPSR_out      in   32  current CPSR from the EU
//  busy          out  1   sequence active; control unit must hold its fetch
//  int_ack       out  2   one-cycle pulse on vector load: [1]=FIQ taken, [0]=IRQ taken
//  SPSR_ld       out  1   EU SPSR load strobe
//  SPSR_fiq_ld   out  1   EU SPSR_fiq load strobe
//  SPSR_fiq_sel  out  1   always 0 (SPSR_fiq loads from CPSR_out)
//  Link_ld       out  1   EU Link load strobe
//  Link_fiq_ld   out  1   EU Link_fiq load strobe
//  Link_fiq_sel  out  1   always 0
//  CPSR_sel      out  3   CPSR mux select: 2=SPSR, 3=SPSR_fiq, 4=change_flags
//  CPSR_ld       out  3   CPSR field loads
//  change_flags  out  32  masked PSR value for CPSR_sel=4
//  IP_sel        out  3   IP source select
//  IP_ld         out  1   IP load strobe
//  in_irq        out  1   IRQ handler active
//  in_fiq        out  1   FIQ handler active
// BEHAVIOUR
//  Reset values: every output is 0; in_irq=in_fiq=0; state=IDLE; synchronisers cleared.
//  Synchroniser: irq_s and fiq_s are the last flop of the SYNC_STAGES chain.
//    Input-to-visible latency is SYNC_STAGES cycles.
//  Take conditions, evaluated only in IDLE with boundary=1:
//    take_fiq = fiq_s & ~CPSR_out[F_BIT] & ~in_fiq
//    take_irq = irq_s & ~CPSR_out[I_BIT] & ~in_irq & ~in_fiq & ~take_fiq
//  FSM states: IDLE, SAVE, MASK, VECT, RESTORE, RETIP. busy=1 in every state except IDLE.
//  Register kind_fiq records which sequence is running.
//  IDLE -> SAVE on take_fiq or take_irq.
//  IDLE -> RESTORE on reti with in_fiq|in_irq. reti beats a request in the same cycle.
//  reti with neither flag set is ignored (no strobes, stays IDLE).
//  SAVE (1 cycle):
//    FIQ: SPSR_fiq_ld=1, Link_fiq_ld=1.
//    IRQ: SPSR_ld=1, Link_ld=1.
//    -> MASK
//  MASK (1 cycle): CPSR_sel=4, CPSR_ld=3'b111.
//    FIQ: change_flags = CPSR_out with bits F_BIT and I_BIT set.
//    IRQ: change_flags = CPSR_out with bit I_BIT set.
//    -> VECT
//  VECT (1 cycle): IP_sel = FIQ_VEC_SEL or IRQ_VEC_SEL, IP_ld=1, int_ack pulses.
//    Sets in_fiq or in_irq. -> IDLE
//  RESTORE (1 cycle): restores the innermost handler.
//    in_fiq=1: CPSR_sel=3, CPSR_ld=3'b111; in_fiq clears at the end of the cycle.
//    otherwise: CPSR_sel=2, CPSR_ld=3'b111; in_irq clears.
//    -> RETIP
//  RETIP (1 cycle): IP_sel=RET_SEL, IP_ld=1. -> IDLE
//  Latencies: entry is 3 cycles after the IDLE take; return is 2 cycles.
//  Outside their active state, all strobes are 0 and CPSR_sel/IP_sel are 0.
//  Nesting:
//    FIQ may preempt an IRQ handler (in_irq stays 1).
//    IRQ never preempts an FIQ handler.
//    A second reti returns to the IRQ level.
//  Requests that drop before sampling are lost (level-sensitive, not latched).
//  Reset asserted in any state: next cycle returns to the reset values; a partial sequence is abandoned.
// STRUCTURE
//  Shared package: FSM state encodings, the CPSR_sel codes (2, 3, 4) and the I_BIT/F_BIT defaults.
//  One sub-module, sync_bit (SYNC_STAGES-deep synchroniser with synchronous reset), instantiated twice.
//  Everything else is a single FSM plus the in_irq/in_fiq/kind_fiq flags.
// TESTING
//  1. irq_in=1, CPSR_out=0, boundary=1:
//     SPSR_ld and Link_ld 2 cycles after sync, then CPSR_sel=4 with change_flags=32'h400,
//     then IP_sel=3 with IP_ld=1 and int_ack=2'b01; in_irq=1.
//  2. irq_in and fiq_in rise together: FIQ is taken with change_flags=32'h2400 and int_ack=2'b10;
//     IRQ is not taken while in_fiq=1.
//  3. In an IRQ handler with CPSR_out=32'h400, fiq_in=1: FIQ is taken; then reti restores via CPSR_sel=3.
//     A second reti restores via CPSR_sel=2; in_irq=0 and in_fiq=0 at the end.
//  4. reti and irq_in in the same IDLE cycle: RESTORE first; the IRQ is taken on the next boundary after RETIP.
//  5. reset=1 in the MASK state: the next cycle has all outputs 0 and busy=0; a reti with no flags set produces no strobes.
//  6. irq_in=1 with CPSR_out[10]=1, or boundary=0: no strobes for 20 cycles;
//     clearing the mask bit gives entry after 1 cycle.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Interrupt sequencer shared definitions.
// FSM encodings, CPSR mux codes and default CPSR mask bit positions.
package int_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_MASK,
    S_VECT,
    S_RESTORE,
    S_RETIP
  } state_t;

  localparam logic [2:0] CSEL_SPSR     = 3'd2;
  localparam logic [2:0] CSEL_SPSR_FIQ = 3'd3;
  localparam logic [2:0] CSEL_FLAGS    = 3'd4;

  localparam int SYNC_DEF  = 2;
  localparam int I_BIT_DEF = 10;
  localparam int F_BIT_DEF = 13;

  localparam logic [2:0] IRQ_VEC_DEF = 3'd3;
  localparam logic [2:0] FIQ_VEC_DEF = 3'd4;
  localparam logic [2:0] RET_DEF     = 3'd5;

endpackage

// File: rtl/int_ctrl_unit_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input.
// Synchronous active-high clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/int_ctrl_unit.sv
// Interrupt entry/return sequencer in front of the execution unit.
// FIQ beats IRQ; reti beats a new request in the same IDLE cycle.
module int_ctrl_unit
  import int_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = SYNC_DEF,
  parameter int         I_BIT       = I_BIT_DEF,
  parameter int         F_BIT       = F_BIT_DEF,
  parameter logic [2:0] IRQ_VEC_SEL = IRQ_VEC_DEF,
  parameter logic [2:0] FIQ_VEC_SEL = FIQ_VEC_DEF,
  parameter logic [2:0] RET_SEL     = RET_DEF
) (
  input  logic        W_Clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        fiq_in,
  input  logic        boundary,
  input  logic        reti,
  input  logic [31:0] CPSR_out,
  output logic        busy,
  output logic [1:0]  int_ack,
  output logic        SPSR_ld,
  output logic        SPSR_fiq_ld,
  output logic        SPSR_fiq_sel,
  output logic        Link_ld,
  output logic        Link_fiq_ld,
  output logic        Link_fiq_sel,
  output logic [2:0]  CPSR_sel,
  output logic [2:0]  CPSR_ld,
  output logic [31:0] change_flags,
  output logic [2:0]  IP_sel,
  output logic        IP_ld,
  output logic        in_irq,
  output logic        in_fiq
);

  state_t state, next;
  logic   kind_fiq;
  logic   irq_s, fiq_s;
  logic   take_fiq, take_irq;
  logic   start, ret;
  logic [31:0] mask;

  sync_bit #(.STAGES(SYNC_STAGES)) u_irq (
    .clk(W_Clk), .reset(reset), .d(irq_in), .q(irq_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_fiq (
    .clk(W_Clk), .reset(reset), .d(fiq_in), .q(fiq_s)
  );

  assign take_fiq = fiq_s & ~CPSR_out[F_BIT] & ~in_fiq;
  assign take_irq = irq_s & ~CPSR_out[I_BIT] & ~in_irq
                  & ~in_fiq & ~take_fiq;
  assign start = boundary & (take_fiq | take_irq);
  assign ret   = reti & (in_fiq | in_irq);

  assign SPSR_fiq_sel = 1'b0;
  assign Link_fiq_sel = 1'b0;

  always_ff @(posedge W_Clk) begin
    if (reset) begin
      state    <= S_IDLE;
      kind_fiq <= 1'b0;
      in_irq   <= 1'b0;
      in_fiq   <= 1'b0;
    end else begin
      state <= next;
      if (state == S_IDLE && !ret && start)
        kind_fiq <= take_fiq;
      if (state == S_VECT) begin
        if (kind_fiq) in_fiq <= 1'b1;
        else          in_irq <= 1'b1;
      end
      // innermost handler unwinds first
      if (state == S_RESTORE) begin
        if (in_fiq) in_fiq <= 1'b0;
        else        in_irq <= 1'b0;
      end
    end
  end

  always_comb begin
    mask = '0;
    mask[I_BIT] = 1'b1;
    if (kind_fiq) mask[F_BIT] = 1'b1;
  end

  always_comb begin
    next         = state;
    busy         = (state != S_IDLE);
    int_ack      = 2'b00;
    SPSR_ld      = 1'b0;
    SPSR_fiq_ld  = 1'b0;
    Link_ld      = 1'b0;
    Link_fiq_ld  = 1'b0;
    CPSR_sel     = 3'd0;
    CPSR_ld      = 3'b000;
    change_flags = '0;
    IP_sel       = 3'd0;
    IP_ld        = 1'b0;
    case (state)
      S_IDLE: begin
        unique case (1'b1)
          ret:     next = S_RESTORE;
          start:   next = S_SAVE;
          default: next = S_IDLE;
        endcase
      end
      S_SAVE: begin
        SPSR_fiq_ld = kind_fiq;
        Link_fiq_ld = kind_fiq;
        SPSR_ld     = ~kind_fiq;
        Link_ld     = ~kind_fiq;
        next        = S_MASK;
      end
      S_MASK: begin
        CPSR_sel     = CSEL_FLAGS;
        CPSR_ld      = 3'b111;
        change_flags = CPSR_out | mask;
        next         = S_VECT;
      end
      S_VECT: begin
        IP_sel  = kind_fiq ? FIQ_VEC_SEL : IRQ_VEC_SEL;
        IP_ld   = 1'b1;
        int_ack = kind_fiq ? 2'b10 : 2'b01;
        next    = S_IDLE;
      end
      S_RESTORE: begin
        CPSR_sel = in_fiq ? CSEL_SPSR_FIQ : CSEL_SPSR;
        CPSR_ld  = 3'b111;
        next     = S_RETIP;
      end
      S_RETIP: begin
        IP_sel = RET_SEL;
        IP_ld  = 1'b1;
        next   = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl_unit.sv
// Scoreboard bench for int_ctrl_unit.
// Directed stimulus pushes cycle-stamped expectations; a negedge monitor checks.
module tb_int_ctrl_unit;

  logic        W_Clk = 1'b0;
  logic        reset, irq_in, fiq_in, boundary, reti;
  logic [31:0] CPSR_out;
  logic        busy, SPSR_ld, SPSR_fiq_ld, SPSR_fiq_sel;
  logic        Link_ld, Link_fiq_ld, Link_fiq_sel, IP_ld;
  logic        in_irq, in_fiq;
  logic [1:0]  int_ack;
  logic [2:0]  CPSR_sel, CPSR_ld, IP_sel;
  logic [31:0] change_flags;

  int_ctrl_unit dut (
    .W_Clk(W_Clk), .reset(reset),
    .irq_in(irq_in), .fiq_in(fiq_in),
    .boundary(boundary), .reti(reti),
    .CPSR_out(CPSR_out), .busy(busy),
    .int_ack(int_ack),
    .SPSR_ld(SPSR_ld), .SPSR_fiq_ld(SPSR_fiq_ld),
    .SPSR_fiq_sel(SPSR_fiq_sel),
    .Link_ld(Link_ld), .Link_fiq_ld(Link_fiq_ld),
    .Link_fiq_sel(Link_fiq_sel),
    .CPSR_sel(CPSR_sel), .CPSR_ld(CPSR_ld),
    .change_flags(change_flags),
    .IP_sel(IP_sel), .IP_ld(IP_ld),
    .in_irq(in_irq), .in_fiq(in_fiq)
  );

  always #5 W_Clk = ~W_Clk;

  typedef struct packed {
    int          cyc;
    logic        b;
    logic        sl, sfl, ll, lfl;
    logic [2:0]  csel, cld;
    logic [31:0] cf;
    logic [2:0]  ips;
    logic        ipl;
    logic [1:0]  ack;
  } ev_t;

  typedef struct packed {
    int         cyc;
    logic [3:0] v;
  } fl_t;

  ev_t sq[$];
  fl_t fq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  done = 0;

  always @(posedge W_Clk) cyc <= cyc + 1;

  function automatic ev_t ev0(int c);
    ev_t e;
    e = '0;
    e.cyc = c;
    e.b = 1'b1;
    return e;
  endfunction

  task automatic exp_entry(int c, bit f, logic [31:0] cf);
    ev_t e;
    e = ev0(c);
    if (f) begin e.sfl = 1; e.lfl = 1; end
    else   begin e.sl = 1; e.ll = 1; end
    sq.push_back(e);
    e = ev0(c + 1);
    e.csel = 3'd4; e.cld = 3'b111; e.cf = cf;
    sq.push_back(e);
    e = ev0(c + 2);
    e.ips = f ? 3'd4 : 3'd3; e.ipl = 1;
    e.ack = f ? 2'b10 : 2'b01;
    sq.push_back(e);
  endtask

  task automatic exp_ret(int c, logic [2:0] cs);
    ev_t e;
    e = ev0(c);
    e.csel = cs; e.cld = 3'b111;
    sq.push_back(e);
    e = ev0(c + 1);
    e.ips = 3'd5; e.ipl = 1;
    sq.push_back(e);
  endtask

  // v = {busy, in_irq, in_fiq, quiet}
  task automatic exp_flags(int c, logic [3:0] v);
    fl_t f;
    f.cyc = c;
    f.v = v;
    fq.push_back(f);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge W_Clk);
    #1;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step(1);
    reti = 1'b0;
  endtask

  always @(negedge W_Clk) begin
    ev_t a, e;
    fl_t f;
    logic present, quiet;
    a.cyc = cyc; a.b = busy;
    a.sl = SPSR_ld; a.sfl = SPSR_fiq_ld;
    a.ll = Link_ld; a.lfl = Link_fiq_ld;
    a.csel = CPSR_sel; a.cld = CPSR_ld;
    a.cf = change_flags; a.ips = IP_sel;
    a.ipl = IP_ld; a.ack = int_ack;
    present = |{SPSR_ld, SPSR_fiq_ld, Link_ld,
                Link_fiq_ld, CPSR_ld, IP_ld, int_ack};
    quiet = ~busy & ~present & ~SPSR_fiq_sel
          & ~Link_fiq_sel & ~|CPSR_sel & ~|IP_sel
          & ~|change_flags;
    while (sq.size() > 0 && sq[0].cyc < cyc && !present) begin
      e = sq.pop_front();
      total++; bad++;
      $display("FAIL missing_strobe cyc=%0d want=%h",
               e.cyc, e);
    end
    if (present === 1'b1) begin
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe got=%h", a);
      end else begin
        e = sq.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL strobe got=%h want=%h", a, e);
        end
      end
    end
    while (fq.size() > 0 && fq[0].cyc <= cyc) begin
      f = fq.pop_front();
      total++;
      if (f.cyc != cyc ||
          {busy, in_irq, in_fiq, quiet} !== f.v) begin
        bad++;
        $display("FAIL flags cyc=%0d got=%b want=%b@%0d",
                 cyc, {busy, in_irq, in_fiq, quiet},
                 f.v, f.cyc);
      end
    end
    if (done || cyc > 3000) begin
      total++;
      if (!done || sq.size() != 0 || fq.size() != 0) begin
        bad++;
        $display("FAIL drain done=%0d ev_left=%0d fl_left=%0d",
                 done, sq.size(), fq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    int n;
    reset = 1; irq_in = 0; fiq_in = 0;
    boundary = 1; reti = 0; CPSR_out = '0;
    step(3);
    exp_flags(cyc, 4'b0001);
    step(1);
    reset = 0;
    step(2);

    // plain IRQ entry
    n = cyc;
    irq_in = 1;
    exp_entry(n + 3, 0, 32'h400);
    exp_flags(n + 6, 4'b0101);
    step(6);
    irq_in = 0;
    step(3);

    // FIQ preempts IRQ handler, then two returns
    CPSR_out = 32'h400;
    n = cyc;
    fiq_in = 1;
    exp_entry(n + 3, 1, 32'h2400);
    exp_flags(n + 6, 4'b0111);
    step(6);
    fiq_in = 0;
    step(3);
    exp_ret(cyc + 1, 3'd3);
    pulse_reti();
    step(2);
    exp_flags(cyc, 4'b0101);
    exp_ret(cyc + 1, 3'd2);
    pulse_reti();
    step(2);
    exp_flags(cyc, 4'b0001);
    CPSR_out = '0;

    // simultaneous IRQ+FIQ: FIQ wins, IRQ held off
    n = cyc;
    irq_in = 1; fiq_in = 1;
    exp_entry(n + 3, 1, 32'h2400);
    step(6);
    step(10);
    exp_flags(cyc, 4'b0011);
    irq_in = 0; fiq_in = 0;
    step(3);
    exp_ret(cyc + 1, 3'd3);
    pulse_reti();
    step(2);
    exp_flags(cyc, 4'b0001);

    // reti collides with a new IRQ request
    CPSR_out = 32'h8000_0001;
    n = cyc;
    irq_in = 1;
    exp_entry(n + 3, 0, 32'h8000_0401);
    step(6);
    irq_in = 0;
    step(3);
    irq_in = 1;
    step(2);
    n = cyc;
    exp_ret(n + 1, 3'd2);
    exp_entry(n + 4, 0, 32'h8000_0401);
    exp_flags(n + 7, 4'b0101);
    pulse_reti();
    step(6);
    irq_in = 0;
    step(3);

    // reset mid-sequence abandons it
    CPSR_out = '0;
    n = cyc;
    fiq_in = 1;
    exp_entry(n + 3, 1, 32'h2400);
    void'(sq.pop_back());
    step(3);
    fiq_in = 0;
    step(1);
    reset = 1;
    step(1);
    exp_flags(cyc, 4'b0001);
    reset = 0;
    pulse_reti();
    step(5);
    exp_flags(cyc, 4'b0001);

    // boundary low, then masked, then unmasked
    boundary = 0;
    irq_in = 1;
    step(20);
    CPSR_out = 32'h400;
    boundary = 1;
    step(20);
    exp_flags(cyc, 4'b0001);
    n = cyc;
    CPSR_out = '0;
    exp_entry(n + 1, 0, 32'h400);
    exp_flags(n + 4, 4'b0101);
    step(4);
    irq_in = 0;
    step(5);
    done = 1;
  end

endmodule
